// File: rtl/lcd_fb_rd_ctrl.sv
`timescale 1ns/1ps
// Frame-buffer read scheduler: burst-reads RGB565 pixels into a FIFO and serves the LCD driver.
// Latency: pixel_data is registered and appears one cycle after data_req.
// Backpressure: a burst is only requested when the FIFO can hold all of it; at most one burst is in flight.
//
// Ports:
//   lcd_pclk, rst            : pixel clock, synchronous active-high reset
//   frame_start              : one-cycle pulse; restarts the frame (flushes FIFO, rewinds address)
//   data_req / pixel_data    : per-pixel request from the timing driver, pixel returned next cycle
//   rd_req/rd_addr/rd_ack    : burst request handshake to the memory port
//   rd_data_valid/rd_data    : returned burst beats
//   fifo_level               : registered FIFO occupancy
//   underflow                : sticky, a request found the FIFO empty during this frame
//   frame_done               : every burst of the frame has been received
module lcd_fb_rd_ctrl #(
    parameter int          H_DISP     = 1024,
    parameter int          V_DISP     = 600,
    parameter int          BURST_LEN  = 64,
    parameter int          FIFO_DEPTH = 256,
    parameter int          ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                          lcd_pclk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic                          data_req,
    output logic [15:0]                   pixel_data,
    output logic                          rd_req,
    output logic [ADDR_W-1:0]             rd_addr,
    input  logic                          rd_ack,
    input  logic                          rd_data_valid,
    input  logic [15:0]                   rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    output logic                          frame_done
);

    localparam int TOTAL  = H_DISP * V_DISP;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_REQ, ST_WAIT_DATA, ST_FLUSH, ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    issued_q, issued_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                done_q, done_d;
    logic                under_q;
    logic [15:0]         pix_q;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]    level_q;
    logic [15:0]         mem_q [FIFO_DEPTH];

    logic free_ok, beat_last, fifo_empty, push, pop;

    assign free_ok    = (LVL_W'(FIFO_DEPTH) - level_q) >= LVL_W'(BURST_LEN);
    assign beat_last  = rd_data_valid && (beat_q == BEAT_W'(BURST_LEN - 1));
    assign fifo_empty = (level_q == '0);
    // A restart wins over everything: no pop, and the beat in that cycle is discarded.
    assign pop        = data_req && !frame_start && !fifo_empty;
    assign push       = (state_q == ST_WAIT_DATA) && rd_data_valid && !frame_start &&
                        (level_q != LVL_W'(FIFO_DEPTH));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        beat_d   = beat_q;
        done_d   = done_q;
        if (frame_start) begin
            addr_d   = BASE_ADDR;
            issued_d = '0;
            done_d   = 1'b0;
            unique case (state_q)
                ST_WAIT_DATA, ST_FLUSH: begin
                    // The in-flight burst still has to be drained. If its last beat lands
                    // in this very cycle there is nothing left to drain, so skip FLUSH.
                    if (rd_data_valid) beat_d = beat_q + BEAT_W'(1);
                    state_d = beat_last ? ST_CHECK : ST_FLUSH;
                end
                default: state_d = ST_CHECK;
            endcase
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_CHECK: begin
                    if (issued_q == CNT_W'(TOTAL)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (free_ok) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (rd_ack) begin
                        addr_d   = addr_q + ADDR_W'(BURST_LEN);
                        issued_d = issued_q + CNT_W'(BURST_LEN);
                        beat_d   = '0;
                        state_d  = ST_WAIT_DATA;
                    end
                end
                // Both count beats; only WAIT_DATA stores them (see push).
                ST_WAIT_DATA, ST_FLUSH: begin
                    if (rd_data_valid) begin
                        beat_d = beat_q + BEAT_W'(1);
                        if (beat_last) state_d = ST_CHECK;
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= BASE_ADDR;
            issued_q <= '0;
            beat_q   <= '0;
            done_q   <= 1'b0;
            under_q  <= 1'b0;
            pix_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            beat_q   <= beat_d;
            done_q   <= done_d;
            pix_q    <= pop ? mem_q[rd_ptr_q] : 16'h0000;
            if (frame_start) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
                under_q  <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
                if (data_req && fifo_empty) under_q <= 1'b1;
            end
        end
    end

    // Storage has no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge lcd_pclk) begin
        if (push) mem_q[wr_ptr_q] <= rd_data;
    end

    assign pixel_data = pix_q;
    assign rd_req     = (state_q == ST_REQ);
    assign rd_addr    = addr_q;
    assign fifo_level = level_q;
    assign underflow  = under_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_lcd_fb_rd_ctrl.sv
`timescale 1ns/1ps
module tb_lcd_fb_rd_ctrl;

    localparam int          H     = 8;
    localparam int          V     = 2;
    localparam int          B     = 4;
    localparam int          D     = 8;
    localparam int          TOTAL = H * V;
    localparam logic [23:0] BASE  = 24'h100;

    logic        lcd_pclk = 1'b0;
    logic        rst = 1'b1, frame_start = 1'b0, data_req = 1'b0;
    logic        ack_auto = 1'b0, ack_force = 1'b0, rd_ack;
    logic        rd_data_valid = 1'b0;
    logic [15:0] rd_data = 16'h0, pixel_data;
    logic        rd_req, underflow, frame_done;
    logic [23:0] rd_addr;
    logic [3:0]  fifo_level;

    assign rd_ack = ack_auto | ack_force;

    always #5 lcd_pclk = ~lcd_pclk;

    lcd_fb_rd_ctrl #(
        .H_DISP(H), .V_DISP(V), .BURST_LEN(B), .FIFO_DEPTH(D),
        .ADDR_W(24), .BASE_ADDR(BASE)
    ) dut (
        .lcd_pclk(lcd_pclk), .rst(rst), .frame_start(frame_start), .data_req(data_req),
        .pixel_data(pixel_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data), .fifo_level(fifo_level),
        .underflow(underflow), .frame_done(frame_done)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    task automatic cyc();
        @(posedge lcd_pclk);
        #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    // ---------------- reference model: pixels as a plain queue ----------------
    logic [15:0] m_fifo[$];
    logic [15:0] exp_pix[$];
    int unsigned burst_addr[$];   // accepted bursts, in order, for the memory responder
    int          m_issued = 0, m_outst = 0;
    bit          m_discard = 0, m_under = 0, m_done = 0, m_pend = 0, seen_edge = 0;
    bit          mem_hold = 0, b2b = 0, collect = 0;
    logic [15:0] seed = 16'h0;
    logic [15:0] seen_pix[$];

    always @(posedge lcd_pclk) begin
        logic [15:0] pv;
        bit          was_empty;
        seen_edge = 1;
        pv = 16'h0;
        if (rst) begin
            m_fifo.delete();
            m_issued = 0; m_outst = 0;
            m_discard = 0; m_under = 0; m_done = 0; m_pend = 0;
        end else begin
            was_empty = (m_fifo.size() == 0);
            if (frame_start) begin
                m_fifo.delete();
                m_issued = 0; m_under = 0; m_done = 0; m_pend = 0;
                if (m_outst > 0) m_discard = 1;
            end else begin
                if (m_pend) begin m_done = 1; m_pend = 0; end
                if (data_req) begin
                    if (was_empty) m_under = 1;
                    else pv = m_fifo.pop_front();
                end
            end
            if (rd_data_valid && m_outst > 0) begin
                m_outst--;
                if (!m_discard && !frame_start) m_fifo.push_back(rd_data);
                if (m_outst == 0) begin
                    m_discard = 0;
                    if (!frame_start && m_issued == TOTAL) m_pend = 1;
                end
            end
            if (!frame_start && rd_req && rd_ack) begin
                chk("rd_addr_at_ack", {8'h0, rd_addr}, BASE + m_issued);
                burst_addr.push_back(BASE + m_issued);
                m_issued += B;
                m_outst = B;
            end
        end
        exp_pix.push_back(pv);
    end

    // ---------------- monitor ----------------
    always @(negedge lcd_pclk) begin
        if (seen_edge) begin
            if (exp_pix.size() > 0) chk("pixel_data", pixel_data, exp_pix.pop_front());
            chk("fifo_level", fifo_level, m_fifo.size());
            chk("underflow", underflow, m_under);
            chk("frame_done", frame_done, m_done);
            chk("no_overflow", m_fifo.size() <= D, 1);
            if (rd_req) begin
                chk("req_needs_space", m_fifo.size() <= D - B, 1);
                chk("req_one_outstanding", (m_issued < TOTAL) && (m_outst == 0), 1);
            end
            if (collect && pixel_data != 16'h0) seen_pix.push_back(pixel_data);
        end
    end

    // ---------------- memory responder ----------------
    initial begin
        int dly, cnt, beat, sent;
        dly = 2; cnt = 0; beat = 0; sent = 0;
        forever begin
            cyc();
            ack_auto = 1'b0;
            if (rd_req && !mem_hold) begin
                if (cnt >= dly) begin
                    ack_auto = 1'b1;
                    cnt = 0;
                    dly = b2b ? 2 : $urandom_range(0, 3);
                end else cnt++;
            end else cnt = 0;
            rd_data_valid = 1'b0;
            if (sent < burst_addr.size() && (b2b || $urandom_range(0, 2) != 0)) begin
                rd_data_valid = 1'b1;
                rd_data = 16'(burst_addr[sent] - 32'h100 + beat + 1 + seed);
                beat++;
                if (beat == B) begin beat = 0; sent++; end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int t, lvl_max;
        lvl_max = 0;

        // Reset
        repeat (3) cyc();
        chk("rst_rd_addr", {8'h0, rd_addr}, BASE);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_pixel", pixel_data, 0);
        chk("rst_level", fifo_level, 0);
        rst = 1'b0;
        repeat (5) begin
            cyc();
            chk("idle_rd_req", rd_req, 0);
        end

        // Fill with no requests: two bursts fill the FIFO, the third must wait
        b2b = 1; seed = 16'h0;
        pulse_fs();
        repeat (60) begin
            cyc();
            if (fifo_level > lvl_max) lvl_max = fifo_level;
        end
        chk("fill_level_peak", lvl_max, 8);
        chk("fill_no_req", rd_req, 0);
        chk("fill_not_done", frame_done, 0);

        // Two lines of 8 requests, each started once the FIFO is full
        collect = 1;
        for (int ln = 0; ln < V; ln++) begin
            t = 0;
            while (fifo_level != 4'd8 && t < 200) begin cyc(); t++; end
            if (t >= 200) timeout("wait_fifo_full");
            data_req = 1'b1;
            repeat (H) cyc();
            data_req = 1'b0;
        end
        repeat (20) cyc();
        collect = 0;
        chk("line_frame_done", frame_done, 1);
        chk("line_no_underflow", underflow, 0);
        chk("line_pixel_count", seen_pix.size(), TOTAL);
        for (int i = 0; i < seen_pix.size() && i < TOTAL; i++)
            chk("line_pixel_order", seen_pix[i], i + 1);

        // Underflow: request before any beat has returned, then random drain
        b2b = 0; seed = 16'($urandom);
        pulse_fs();
        data_req = 1'b1;
        cyc();
        data_req = 1'b0;
        chk("early_underflow", underflow, 1);
        chk("early_pixel", pixel_data, 0);
        t = 0;
        while (!frame_done && t < 1500) begin
            data_req = ($urandom_range(0, 2) == 0);
            cyc(); t++;
        end
        data_req = 1'b0;
        if (t >= 1500) timeout("random_drain");
        cyc();
        chk("underflow_sticky", underflow, 1);
        pulse_fs();
        chk("underflow_cleared", underflow, 0);

        // Restart two beats into a burst: the rest is drained and dropped
        t = 0;
        while (m_outst != B && t < 100) begin cyc(); t++; end
        if (t >= 100) timeout("wait_burst_start");
        t = 0;
        while (m_outst != 2 && t < 100) begin cyc(); t++; end
        if (t >= 100) timeout("wait_two_beats");
        pulse_fs();
        t = 0;
        while (!rd_req && t < 100) begin
            chk("flush_level", fifo_level, 0);
            cyc(); t++;
        end
        if (t >= 100) timeout("wait_req_after_flush");
        chk("flush_rerequest_addr", {8'h0, rd_addr}, BASE);

        // Simultaneous push and pop at level 5
        b2b = 1; seed = 16'($urandom);
        pulse_fs();
        t = 0;
        while (fifo_level != 4'd5 && t < 200) begin cyc(); t++; end
        if (t >= 200) timeout("wait_level5");
        data_req = 1'b1;
        cyc();
        data_req = 1'b0;
        chk("pushpop_level", fifo_level, 5);
        chk("pushpop_oldest", pixel_data, 16'(seed + 16'd1));

        // Restart in the same cycle as an ack: the ack is ignored
        mem_hold = 1;
        pulse_fs();
        t = 0;
        while (!rd_req && t < 100) begin cyc(); t++; end
        if (t >= 100) timeout("wait_req_hold");
        ack_force = 1'b1;
        frame_start = 1'b1;
        cyc();
        ack_force = 1'b0;
        frame_start = 1'b0;
        chk("abort_rd_req_drop", rd_req, 0);
        chk("abort_rd_addr", {8'h0, rd_addr}, BASE);
        mem_hold = 0;
        t = 0;
        while (!rd_req && t < 100) begin cyc(); t++; end
        if (t >= 100) timeout("wait_rerequest");
        chk("abort_rerequest_addr", {8'h0, rd_addr}, BASE);
        t = 0;
        while (!frame_done && t < 1500) begin
            data_req = ($urandom_range(0, 1) == 0);
            cyc(); t++;
        end
        data_req = 1'b0;
        if (t >= 1500) timeout("final_drain");
        repeat (4) cyc();
        chk("final_frame_done", frame_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
